operand_fetch: RTL
==================

Name: operand_fetch

Overview:
- Read-side companion to the general register file (GRF) in the pipelined MIPS core.
- Accepts decoded instructions, drives GRF read addresses and captures operands.
- Tracks pending register writes in a busy-bit scoreboard and stalls on RAW/WAW hazards.
- Snoops the GRF write port to bypass same-cycle writeback data, then hands operands to execute through a registered valid/ready output.

Parameters:
- STALL_CNT_W, 32, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  decoded instruction present.
- in_ready  output  1  instruction accepted this cycle (combinational).
- in_rs  input  5  source register 1.
- in_rt  input  5  source register 2.
- in_rd  input  5  destination register.
- in_wen  input  1  instruction writes in_rd.
- in_pc  input  32  instruction PC.
- grfA1  output  5  GRF read address 1; equals in_rs (combinational).
- grfA2  output  5  GRF read address 2; equals in_rt (combinational).
- grfRD1  input  32  GRF read data 1 (combinational read).
- grfRD2  input  32  GRF read data 2.
- wb_valid  input  1  GRF write enable (snooped).
- wb_addr  input  5  GRF write address.
- wb_data  input  32  GRF write data.
- out_valid  output  1  operand bundle valid.
- out_ready  input  1  execute stage accepts the bundle.
- out_op1  output  32  operand 1.
- out_op2  output  32  operand 2.
- out_rd  output  5  destination register.
- out_wen  output  1  destination write flag.
- out_pc  output  32  PC.
- stall_cycles  output  STALL_CNT_W  count of hazard/backpressure stall cycles.

Behaviour:
- Reset (highest priority, synchronous):
  - busy[31:0], out_valid, out_op1, out_op2, out_rd, out_wen, out_pc and stall_cycles all go to 0.
  - wb_* is ignored in a reset cycle.
- Scoreboard:
  - busy[0] is hard-wired to 0.
  - busy[r] = 1 means an accepted instruction has a pending write to r.
- Bypass match: wbm(x) = wb_valid && wb_addr == x && x != 0.
- Hazard:
  - raw = (busy[in_rs] && !wbm(in_rs)) || (busy[in_rt] && !wbm(in_rt)).
  - waw = in_wen && busy[in_rd] && !wbm(in_rd).
  - hazard = raw || waw.
- Handshake:
  - slot_free = !out_valid || out_ready.
  - in_ready = slot_free && !hazard. It is driven whether or not in_valid is high, and has no dependency on out_ready beyond slot_free.
  - accept = in_valid && in_ready.
- Operand select, evaluated at accept:
  - op1 = 0 if in_rs == 0; else wb_data if wbm(in_rs); else grfRD1.
  - op2 uses the same rule with in_rt and grfRD2.
- Output register:
  - On accept: out_* load op1, op2, in_rd, (in_wen && in_rd != 0), in_pc; out_valid = 1. Latency is 1 cycle from accept to out_valid.
  - Else if out_valid && out_ready: out_valid = 0.
  - Else: all out_* hold stable. Data must not change while out_valid && !out_ready.
  - Back-to-back: accept in the same cycle as out_ready reloads the register; out_valid stays 1.
- Scoreboard update per cycle:
  - wb_valid && wb_addr != 0 clears busy[wb_addr]. A clear on a non-busy register is a no-op.
  - accept && in_wen && in_rd != 0 sets busy[in_rd].
  - If set and clear target the same register in the same cycle, set wins.
- Stall counter:
  - Increments when in_valid && !in_ready.
  - Saturates at all-ones; never wraps.
- Reset mid-stall drops the held instruction and clears all pending busy bits. Upstream re-presents the instruction after reset.
- No internal FSM beyond out_valid (EMPTY/FULL). EMPTY->FULL on accept. FULL->EMPTY on out_ready without accept.

Optional Feature:
- Macro: OPFETCH_TRACE_EN.
- Defined: on every accept, $display("@%h: issue rs=$%d rt=$%d rd=$%d", in_pc, in_rs, in_rt, in_rd). Also on every hazard stall cycle, $display("@%h: stall", in_pc).
- Undefined: no display statements are compiled. Functional behaviour is identical.

Test Plan:
- Reset: hold reset 2 cycles with in_valid=1, in_rs=5 -> out_valid=0, stall_cycles=0, busy all 0. First cycle after reset: in_ready=1.
- RAW stall then bypass:
  - Accept pc=0x3000, rd=3, wen=1. Next cycle present rs=3, out_ready=1 -> in_ready=0 and stall_cycles increments.
  - Then wb_valid=1, wb_addr=3, wb_data=0x00001234, with grfRD1=0 -> accepted that cycle; next cycle out_op1=0x00001234 and busy[3]=0.
- $0 handling: rs=0, rt=0, grfRD1=grfRD2=0xdeadbeef, wb_valid=1, wb_addr=0, in_rd=0, in_wen=1 -> out_op1=out_op2=0, out_wen=0, busy unchanged.
- Backpressure:
  - out_valid=1 with out_ready=0 for 3 cycles, new in_valid -> in_ready=0; out_* stable; stall_cycles += 3.
  - out_ready=1 -> new bundle loads the same cycle; out_valid stays 1.
- Simultaneous set/clear: busy[7]=1, wb clears 7 while accepting a wen instruction with rd=7 -> busy[7]=1 afterwards. A following reader of $7 stalls.
- Saturation: with STALL_CNT_W=4, stall 20 cycles -> stall_cycles=4'hF.

Source files
------------

// File: rtl/operand_fetch.sv
// operand_fetch: GRF read-side issue stage with busy-bit scoreboard, writeback bypass and registered valid/ready output.
// Ports: decoded instruction in (in_*), GRF read port (grfA*/grfRD*), snooped GRF write port (wb_*),
//        operand bundle out (out_*), saturating stall counter (stall_cycles).
// Optional: define OPFETCH_TRACE_EN to print issue/stall trace lines.
module operand_fetch #(
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4:0]             in_rs,
  input  logic [4:0]             in_rt,
  input  logic [4:0]             in_rd,
  input  logic                   in_wen,
  input  logic [31:0]            in_pc,
  output logic [4:0]             grfA1,
  output logic [4:0]             grfA2,
  input  logic [31:0]            grfRD1,
  input  logic [31:0]            grfRD2,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_addr,
  input  logic [31:0]            wb_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_op1,
  output logic [31:0]            out_op2,
  output logic [4:0]             out_rd,
  output logic                   out_wen,
  output logic [31:0]            out_pc,
  output logic [STALL_CNT_W-1:0] stall_cycles
);
  logic [31:0] busy_q, busy_d;
  logic out_valid_q, out_valid_d, out_wen_q, out_wen_d;
  logic [31:0] out_op1_q, out_op1_d, out_op2_q, out_op2_d, out_pc_q, out_pc_d;
  logic [4:0] out_rd_q, out_rd_d;
  logic [STALL_CNT_W-1:0] stall_q, stall_d;
  logic m_rs, m_rt, m_rd, hazard, accept;
  assign grfA1 = in_rs;
  assign grfA2 = in_rt;
  assign out_valid = out_valid_q;
  assign out_op1 = out_op1_q;
  assign out_op2 = out_op2_q;
  assign out_rd = out_rd_q;
  assign out_wen = out_wen_q;
  assign out_pc = out_pc_q;
  assign stall_cycles = stall_q;
  always_comb begin
    m_rs = wb_valid && wb_addr == in_rs && in_rs != 5'd0;
    m_rt = wb_valid && wb_addr == in_rt && in_rt != 5'd0;
    m_rd = wb_valid && wb_addr == in_rd && in_rd != 5'd0;
    // a register being written back this cycle is no longer a hazard
    hazard = (busy_q[in_rs] && !m_rs) || (busy_q[in_rt] && !m_rt) || (in_wen && busy_q[in_rd] && !m_rd);
    in_ready = (!out_valid_q || out_ready) && !hazard;
    accept = in_valid && in_ready;
    out_valid_d = accept ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    out_op1_d = !accept ? out_op1_q : in_rs == 5'd0 ? 32'd0 : m_rs ? wb_data : grfRD1;
    out_op2_d = !accept ? out_op2_q : in_rt == 5'd0 ? 32'd0 : m_rt ? wb_data : grfRD2;
    out_rd_d = accept ? in_rd : out_rd_q;
    out_wen_d = accept ? (in_wen && in_rd != 5'd0) : out_wen_q;
    out_pc_d = accept ? in_pc : out_pc_q;
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_addr] = 1'b0;
    // set after clear so a same-register set wins
    if (accept && in_wen) busy_d[in_rd] = 1'b1;
    busy_d[0] = 1'b0;
    stall_d = (in_valid && !in_ready && ~&stall_q) ? stall_q + STALL_CNT_W'(1) : stall_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      out_valid_q <= 1'b0;
      out_op1_q <= '0;
      out_op2_q <= '0;
      out_rd_q <= '0;
      out_wen_q <= 1'b0;
      out_pc_q <= '0;
      stall_q <= '0;
    end else begin
      busy_q <= busy_d;
      out_valid_q <= out_valid_d;
      out_op1_q <= out_op1_d;
      out_op2_q <= out_op2_d;
      out_rd_q <= out_rd_d;
      out_wen_q <= out_wen_d;
      out_pc_q <= out_pc_d;
      stall_q <= stall_d;
    end
  end
`ifdef OPFETCH_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && accept) $display("@%h: issue rs=$%d rt=$%d rd=$%d", in_pc, in_rs, in_rt, in_rd);
    if (!reset && in_valid && hazard) $display("@%h: stall", in_pc);
  end
`else
`endif
endmodule
